spi_reg_bridge: RTL and testbench

Parametrised SPI-slave-to-register bridge, the multi-channel successor to the single-peripheral SPI test harness access path. It synchronises raw SPI pins into the system clock domain, decodes a command byte, and drives a register bus shared by up to 8 peripheral channels. Data width is configurable, reads and writes go to a selectable channel, and an optional burst mode auto-increments the address. It sits between the `uio_in`/`uio_out` SPI pins and the peripherals under test in the harness top level.

---
 rtl/spi_reg_bridge.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//
// SPI slave (mode 0, MSB first) to multi-channel register bus bridge. The raw SPI pins are
// synchronised into the clk domain. A command byte selects read/write, channel and address,
// and one data word follows it.
//
// Frame: cmd[7] = R/nW (1 = read), then CH_W channel bits, then ADDR_W address bits. Any
// remaining low bits are ignored. The command is followed by a DATA_W-bit data word.
//
// Optional feature macro: SPI_BURST_EN
//   defined   : the frame keeps streaming words and reg_addr auto-increments
//               (mod 2^ADDR_W) after each word until CS rises.
//   undefined : one word per frame. Later SCK edges are ignored.
//
// Parameters:
//   ADDR_W      register address width per channel
//   DATA_W      register data width (8, 16 or 32)
//   CHANNELS    number of peripheral channels (1..8), 1 + CH_W + ADDR_W <= 8
//   SYNC_STAGES synchroniser depth on every SPI input (>= 2)
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   spi_cs_n        async chip select, active low
//   spi_clk         async SPI clock (mode 0)
//   spi_mosi        async serial data in
//   spi_miso        registered serial data out, 0 outside a read data phase
//   reg_addr        register address
//   reg_sel         one-hot channel select, zero when idle or the channel is invalid
//   reg_wdata       write data
//   reg_write       one-cycle write strobe
//   reg_read        one-cycle read strobe, reg_rdata captured on the following clock edge
//   reg_rdata       packed read data, channel k at [k*DATA_W +: DATA_W]
//   busy            high while a frame is being handled

module spi_reg_bridge #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         spi_cs_n,
    input  logic                         spi_clk,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    output logic [ADDR_W-1:0]            reg_addr,
    output logic [CHANNELS-1:0]          reg_sel,
    output logic [DATA_W-1:0]            reg_wdata,
    output logic                         reg_write,
    output logic                         reg_read,
    input  logic [CHANNELS*DATA_W-1:0]   reg_rdata,
    output logic                         busy
);

    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CMD_N   = 1 + CH_W + ADDR_W;
    localparam int unsigned CMD_PAD = 8 - CMD_N;

    // ------------------------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   cs_prev_q;
    logic                   sck_prev_q;
    logic                   cs_fall_q;
    logic                   cs_rise_q;
    logic                   sck_rise_q;
    logic                   sck_fall_q;
    logic                   mosi_q;

    logic cs_s;
    logic sck_s;
    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign sck_s = sck_sync_q[SYNC_STAGES-1];

    // CS synchroniser resets to "selected" so that a CS already low at reset release never
    // looks like a fall; a genuine frame needs CS to rise and fall again.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            sck_rise_q  <= 1'b0;
            sck_fall_q  <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
            cs_fall_q   <= cs_prev_q & ~cs_s;
            cs_rise_q   <= ~cs_prev_q & cs_s;
            sck_rise_q  <= ~sck_prev_q & sck_s;
            sck_fall_q  <= sck_prev_q & ~sck_s;
            // Delayed with the edge pulses so the sampled bit lines up with sck_rise_q.
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
        end
    end

    // ------------------------------------------------------------------------------------
    // Command decode and read-data mux
    // ------------------------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;

    state_e              state_q;
    logic [5:0]          bit_cnt_q;
    logic [DATA_W-1:0]   rx_sh_q;
    logic [DATA_W-1:0]   tx_sh_q;
    logic                word_done_q;
    logic [CH_W-1:0]     ch_q;
    logic                ch_valid_q;
`ifdef SPI_BURST_EN
    logic                addr_inc_q;
`endif

    logic [CMD_N-1:0]    cmd_top;
    logic                cmd_rnw;
    logic [CH_W-1:0]     cmd_ch;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [CHANNELS-1:0] cmd_sel;
    logic                cmd_valid;
    logic [DATA_W-1:0]   rdata_sel;
    logic [DATA_W-1:0]   rx_word;

    // Full word including the bit arriving on the current rise.
    assign rx_word  = {rx_sh_q[DATA_W-2:0], mosi_q};
    // Drop the ignored low command bits.
    assign cmd_top  = CMD_N'(rx_word[7:0] >> CMD_PAD);
    assign cmd_rnw  = cmd_top[CMD_N-1];
    assign cmd_ch   = cmd_top[ADDR_W +: CH_W];
    assign cmd_addr = cmd_top[ADDR_W-1:0];

    always_comb begin
        cmd_sel   = '0;
        cmd_valid = 1'b0;
        rdata_sel = '0;
        // Channel indices >= CHANNELS never match, giving a zero select and invalid flag.
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (cmd_ch == CH_W'(k)) begin
                cmd_sel[k] = 1'b1;
                cmd_valid  = 1'b1;
            end
            if (ch_q == CH_W'(k)) begin
                rdata_sel = reg_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // Frame state machine, all bus outputs registered here
    // ------------------------------------------------------------------------------------
    localparam logic [5:0] CMD_LAST  = 6'd7;
    localparam logic [5:0] DATA_LAST = 6'(DATA_W - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            word_done_q <= 1'b0;
            ch_q        <= '0;
            ch_valid_q  <= 1'b0;
            reg_addr    <= '0;
            reg_sel     <= '0;
            reg_wdata   <= '0;
            reg_write   <= 1'b0;
            reg_read    <= 1'b0;
            spi_miso    <= 1'b0;
            busy        <= 1'b0;
`ifdef SPI_BURST_EN
            addr_inc_q  <= 1'b0;
`endif
        end else begin
            reg_write <= 1'b0;
            reg_read  <= 1'b0;
`ifdef SPI_BURST_EN
            // Write address advances after the strobe so the strobe sees the old address.
            addr_inc_q <= 1'b0;
            if (addr_inc_q) begin
                reg_addr <= reg_addr + ADDR_W'(1);
            end
`endif
            // Read data is captured the cycle after the read strobe.
            if (reg_read) begin
                tx_sh_q <= ch_valid_q ? rdata_sel : '0;
            end

            if ((state_q != StIdle) && cs_rise_q) begin
                // Abort: drop any partial word without a strobe.
                state_q     <= StIdle;
                bit_cnt_q   <= '0;
                word_done_q <= 1'b0;
                reg_sel     <= '0;
                spi_miso    <= 1'b0;
                busy        <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cs_fall_q) begin
                            state_q     <= StCmd;
                            bit_cnt_q   <= '0;
                            word_done_q <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end

                    StCmd: begin
                        if (sck_rise_q) begin
                            rx_sh_q <= rx_word;
                            if (bit_cnt_q == CMD_LAST) begin
                                bit_cnt_q  <= '0;
                                reg_addr   <= cmd_addr;
                                ch_q       <= cmd_ch;
                                ch_valid_q <= cmd_valid;
                                reg_sel    <= cmd_sel;
                                if (cmd_rnw) begin
                                    state_q  <= StRdata;
                                    reg_read <= 1'b1;
                                end else begin
                                    state_q <= StWdata;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 6'd1;
                            end
                        end
                    end

                    StWdata: begin
                        if (sck_rise_q && !word_done_q) begin
                            rx_sh_q <= rx_word;
                            if (bit_cnt_q == DATA_LAST) begin
                                bit_cnt_q <= '0;
                                reg_wdata <= rx_word;
                                reg_write <= ch_valid_q;
`ifdef SPI_BURST_EN
                                addr_inc_q <= 1'b1;
`else
                                word_done_q <= 1'b1;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 6'd1;
                            end
                        end
                    end

                    StRdata: begin
                        if (sck_fall_q && !word_done_q) begin
                            spi_miso <= tx_sh_q[DATA_W-1];
                            tx_sh_q  <= {tx_sh_q[DATA_W-2:0], 1'b0};
                        end
                        if (sck_rise_q && !word_done_q) begin
                            if (bit_cnt_q == DATA_LAST) begin
                                bit_cnt_q <= '0;
`ifdef SPI_BURST_EN
                                // Prefetch the next word so it is ready for the next fall.
                                reg_addr <= reg_addr + ADDR_W'(1);
                                reg_read <= 1'b1;
`else
                                word_done_q <= 1'b1;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 6'd1;
                            end
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge. Two instances share the SPI pins:
//   dut_a: CHANNELS=2 (CH_W=1), cmd = {rnw, ch[0], addr[3:0], 2'b00}
//   dut_b: CHANNELS=3 (CH_W=2), cmd = {rnw, ch[1:0], addr[3:0], 1'b0}
// Each directed frame is checked only against the instance it targets.

module tb_spi_reg_bridge;

    localparam int H = 8;  // SCK half period in clk cycles

`ifdef SPI_BURST_EN
    localparam int Burst = 1;
`else
    localparam int Burst = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_cs_n = 1'b1;
    logic spi_clk = 1'b0;
    logic spi_mosi = 1'b0;

    always #5 clk = ~clk;

    localparam logic [15:0] A_RDATA = {8'h3C, 8'h5A};
    localparam logic [23:0] B_RDATA = {8'hC3, 8'h22, 8'h11};

    logic       a_miso, a_write, a_read, a_busy;
    logic [3:0] a_addr;
    logic [1:0] a_sel;
    logic [7:0] a_wdata;
    logic       b_miso, b_write, b_read, b_busy;
    logic [3:0] b_addr;
    logic [2:0] b_sel;
    logic [7:0] b_wdata;

    spi_reg_bridge #(.ADDR_W(4), .DATA_W(8), .CHANNELS(2), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(a_miso), .reg_addr(a_addr), .reg_sel(a_sel), .reg_wdata(a_wdata),
        .reg_write(a_write), .reg_read(a_read), .reg_rdata(A_RDATA), .busy(a_busy)
    );

    spi_reg_bridge #(.ADDR_W(4), .DATA_W(8), .CHANNELS(3), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(b_miso), .reg_addr(b_addr), .reg_sel(b_sel), .reg_wdata(b_wdata),
        .reg_write(b_write), .reg_read(b_read), .reg_rdata(B_RDATA), .busy(b_busy)
    );

    // Uniform views of both instances, index 0 = dut_a, 1 = dut_b.
    logic [1:0]      wr_m, rd_m, busy_m, miso_m;
    logic [1:0][3:0] addr_m;
    logic [1:0][2:0] sel_m;
    logic [1:0][7:0] wdata_m;
    assign wr_m    = {b_write, a_write};
    assign rd_m    = {b_read, a_read};
    assign busy_m  = {b_busy, a_busy};
    assign miso_m  = {b_miso, a_miso};
    assign addr_m  = {b_addr, a_addr};
    assign sel_m   = {b_sel, {1'b0, a_sel}};
    assign wdata_m = {b_wdata, a_wdata};

    // ---------------------------------------------------------------- strobe monitor
    logic       mon_clr = 1'b0;
    int         wr_cnt[2], rd_cnt[2], b2b_cnt[2];
    logic [3:0] first_addr[2];
    logic [3:0] wr_hist[2][3];
    logic [2:0] sel_or[2];
    logic [7:0] last_wdata[2];
    logic [1:0] prev_wr = '0, prev_rd = '0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mon_clr) begin
                wr_cnt[i]     = 0;
                rd_cnt[i]     = 0;
                sel_or[i]     = '0;
                first_addr[i] = '0;
                last_wdata[i] = '0;
            end else begin
                if ((wr_m[i] || rd_m[i]) && (wr_cnt[i] + rd_cnt[i] == 0))
                    first_addr[i] = addr_m[i];
                if (wr_m[i]) begin
                    if (wr_cnt[i] < 3) wr_hist[i][wr_cnt[i]] = addr_m[i];
                    wr_cnt[i]++;
                    last_wdata[i] = wdata_m[i];
                end
                if (rd_m[i]) rd_cnt[i]++;
                if ((wr_m[i] && prev_wr[i]) || (rd_m[i] && prev_rd[i])) b2b_cnt[i]++;
                sel_or[i] = sel_or[i] | sel_m[i];
            end
            prev_wr[i] = wr_m[i];
            prev_rd[i] = rd_m[i];
        end
    end

    // ---------------------------------------------------------------- helpers
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SPI bit, mode 0: MOSI set while SCK low, MISO sampled at the rise.
    task automatic spi_bit(input int tgt, input logic b, output logic mi);
        spi_mosi = b;
        wait_clk(H);
        mi = miso_m[tgt];
        spi_clk = 1'b1;
        wait_clk(H);
        spi_clk = 1'b0;
    endtask

    // Full frame: command byte then nbits of data taken MSB first from data[23:...].
    task automatic run_frame(input int tgt, input logic [7:0] cmd, input logic [23:0] data,
                             input int nbits, output logic [7:0] rx);
        logic mi;
        rx = '0;
        spi_cs_n = 1'b0;
        wait_clk(H);
        for (int i = 7; i >= 0; i--) spi_bit(tgt, cmd[i], mi);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(tgt, data[23-i], mi);
            rx = {rx[6:0], mi};
        end
        wait_clk(H);
        spi_cs_n = 1'b1;
        wait_clk(2 * H);
    endtask

    // ---------------------------------------------------------------- vector table
    typedef struct {
        int         tgt;
        logic [7:0] cmd;
        logic [7:0] data;
        int         exp_wr;
        int         exp_rd;
        logic [3:0] exp_addr;
        logic [2:0] exp_sel;
        logic [7:0] exp_wdata;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] rx;
        logic       mi;

        // a: write ch0 addr3 / read ch1 addr5 / write ch1 addr F / read ch0 addr0
        vecs[0] = '{0, 8'h0C, 8'hA5, 1, 0, 4'h3, 3'b001, 8'hA5, 8'h00};
        vecs[1] = '{0, 8'hD4, 8'h00, 0, 1, 4'h5, 3'b010, 8'h00, 8'h3C};
        vecs[2] = '{0, 8'h7C, 8'h5F, 1, 0, 4'hF, 3'b010, 8'h5F, 8'h00};
        vecs[3] = '{0, 8'h80, 8'h00, 0, 1, 4'h0, 3'b001, 8'h00, 8'h5A};
        // b: write ch3 (invalid) / read ch3 addr9 (invalid) / read ch2 addr1 / write ch1 addr6
        vecs[4] = '{1, 8'h64, 8'h99, 0, 0, 4'h2, 3'b000, 8'h00, 8'h00};
        vecs[5] = '{1, 8'hF2, 8'h00, 0, 1, 4'h9, 3'b000, 8'h00, 8'h00};
        vecs[6] = '{1, 8'hC2, 8'h00, 0, 1, 4'h1, 3'b100, 8'h00, 8'hC3};
        vecs[7] = '{1, 8'h2C, 8'h96, 1, 0, 4'h6, 3'b010, 8'h96, 8'h00};

        // ------------------------------------------------ reset state
        wait_clk(5);
        @(negedge clk);
        check("reset a outputs", {a_miso, a_addr, a_sel, a_wdata, a_write, a_read, a_busy}, 0);
        check("reset b outputs", {b_miso, b_addr, b_sel, b_wdata, b_write, b_read, b_busy}, 0);
        rst = 1'b0;
        wait_clk(10);

        // ------------------------------------------------ table
        for (int i = 0; i < 8; i++) begin
            int t;
            t = vecs[i].tgt;
            clear_mon();
            run_frame(t, vecs[i].cmd, {vecs[i].data, 16'h0}, 8, rx);
            check($sformatf("row%0d wr_cnt", i), wr_cnt[t], vecs[i].exp_wr);
            check($sformatf("row%0d rd_cnt", i), rd_cnt[t], vecs[i].exp_rd * (1 + Burst));
            check($sformatf("row%0d reg_sel", i), sel_or[t], vecs[i].exp_sel);
            if (vecs[i].exp_wr + vecs[i].exp_rd != 0)
                check($sformatf("row%0d reg_addr", i), first_addr[t], vecs[i].exp_addr);
            if (vecs[i].exp_wr != 0)
                check($sformatf("row%0d reg_wdata", i), last_wdata[t], vecs[i].exp_wdata);
            if (vecs[i].exp_rd != 0)
                check($sformatf("row%0d miso word", i), rx, vecs[i].exp_rx);
            check($sformatf("row%0d idle busy/miso", i), {busy_m[t], miso_m[t]}, 0);
        end

        // ------------------------------------------------ abort after 4 data bits
        clear_mon();
        run_frame(0, 8'h0C, {8'hA5, 16'h0}, 4, rx);
        check("abort wr_cnt", wr_cnt[0], 0);
        check("abort busy", busy_m[0], 0);
        clear_mon();
        run_frame(0, 8'h0C, {8'h77, 16'h0}, 8, rx);
        check("post-abort wr_cnt", wr_cnt[0], 1);
        check("post-abort reg_wdata", last_wdata[0], 8'h77);
        check("post-abort reg_addr", first_addr[0], 4'h3);

        // ------------------------------------------------ three words at addr F
        clear_mon();
        run_frame(0, 8'h3C, {8'h11, 8'h22, 8'h33}, 24, rx);
`ifdef SPI_BURST_EN
        check("burst wr_cnt", wr_cnt[0], 3);
        check("burst addr0", wr_hist[0][0], 4'hF);
        check("burst addr1", wr_hist[0][1], 4'h0);
        check("burst addr2", wr_hist[0][2], 4'h1);
        check("burst last wdata", last_wdata[0], 8'h33);
`else
        check("single wr_cnt", wr_cnt[0], 1);
        check("single addr", wr_hist[0][0], 4'hF);
        check("single wdata", last_wdata[0], 8'h11);
`endif

        // ------------------------------------------------ reset in the middle of a read
        clear_mon();
        spi_cs_n = 1'b0;
        wait_clk(H);
        for (int i = 7; i >= 0; i--) spi_bit(0, rx_cmd_bit(8'hD4, i), mi);
        for (int i = 0; i < 3; i++) spi_bit(0, 1'b0, mi);
        check("pre-reset rd_cnt", rd_cnt[0], 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-read reset outputs",
              {a_miso, a_addr, a_sel, a_wdata, a_write, a_read, a_busy}, 0);
        rst = 1'b0;
        clear_mon();
        for (int i = 0; i < 5; i++) spi_bit(0, 1'b1, mi);
        wait_clk(H);
        spi_cs_n = 1'b1;
        wait_clk(2 * H);
        check("post-reset strobes", wr_cnt[0] + rd_cnt[0], 0);
        check("post-reset busy", busy_m[0], 0);
        clear_mon();
        run_frame(0, 8'hD4, 24'h0, 8, rx);
        check("fresh read miso word", rx, 8'h3C);
        check("fresh read rd_cnt", rd_cnt[0], 1 + Burst);

        // ------------------------------------------------ strobe spacing over whole run
        check("a back-to-back strobes", b2b_cnt[0], 0);
        check("b back-to-back strobes", b2b_cnt[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic rx_cmd_bit(input logic [7:0] cmd, input int idx);
        return cmd[idx];
    endfunction

    // Backstop so the run always ends.
    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
